// File: rtl/sync_filter_bank.sv
// Multi-channel level synchroniser with per-channel stability filter and
// registered rise/fall event pulses for asynchronous inputs entering clock.
module sync_filter_bank #(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       STAGES     = 2,
  parameter int unsigned       FILTER_CYC = 3,
  parameter logic [NUM_CH-1:0] RST_VAL    = {NUM_CH{1'b0}}
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] busy
);

  localparam int unsigned      CNT_W   = $clog2(FILTER_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYC - 1);

  // Elaboration-time parameter range checks
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("sync_filter_bank: NUM_CH=%0d outside 1..32", NUM_CH);
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_filter_bank: STAGES=%0d outside 2..4", STAGES);
  end
  if (FILTER_CYC < 1 || FILTER_CYC > 16) begin : g_bad_filter_cyc
    $error("sync_filter_bank: FILTER_CYC=%0d outside 1..16", FILTER_CYC);
  end

  logic [NUM_CH-1:0] sync_q [STAGES];
  logic [NUM_CH-1:0] smp;
  logic [NUM_CH-1:0] lvl_q;
  logic [NUM_CH-1:0] lvl_nxt;
  logic [NUM_CH-1:0] busy_nxt;
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];

  // Plain flop chain; sync_q[0] is the only stage allowed to go metastable
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) sync_q[k] <= RST_VAL;
    end else begin
      sync_q[0] <= async_in;
      for (int k = 1; k < int'(STAGES); k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign smp = sync_q[STAGES-1];

  // A new level is adopted only after FILTER_CYC unbroken mismatching samples
  always_comb begin
    lvl_nxt  = lvl_q;
    busy_nxt = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_nxt[i] = '0;
      if (smp[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_nxt[i] = smp[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      busy_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q      <= RST_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      busy       <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
    end else begin
      lvl_q      <= lvl_nxt;
      rise_pulse <= ~lvl_q & lvl_nxt;
      fall_pulse <= lvl_q & ~lvl_nxt;
      busy       <= busy_nxt;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

  assign sync_out = lvl_q;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: default instance (a) and a STAGES=3/FILTER_CYC=1
// variant (b) share stimulus; a window-based model is checked every negedge.
module tb_sync_filter_bank;

  localparam int         A_ST = 2;
  localparam int         A_FC = 3;
  localparam logic [3:0] A_RV = 4'b0000;
  localparam int         B_ST = 3;
  localparam int         B_FC = 1;
  localparam logic [3:0] B_RV = 4'b1000;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [3:0] async_in;
  logic [3:0] so_a, rp_a, fp_a, bz_a;
  logic [3:0] so_b, rp_b, fp_b, bz_b;

  int   nvec = 0;
  int   nerr = 0;
  logic chk_en = 1'b0;
  logic busy_b_seen = 1'b0;

  always #5 clock = ~clock;

  sync_filter_bank #(
    .NUM_CH(4), .STAGES(A_ST), .FILTER_CYC(A_FC), .RST_VAL(A_RV)
  ) dut_a (
    .clock(clock), .rst_n(rst_n), .async_in(async_in),
    .sync_out(so_a), .rise_pulse(rp_a), .fall_pulse(fp_a), .busy(bz_a)
  );

  sync_filter_bank #(
    .NUM_CH(4), .STAGES(B_ST), .FILTER_CYC(B_FC), .RST_VAL(B_RV)
  ) dut_b (
    .clock(clock), .rst_n(rst_n), .async_in(async_in),
    .sync_out(so_b), .rise_pulse(rp_b), .fall_pulse(fp_b), .busy(bz_b)
  );

  // Model: input history per edge since reset; the sampled stream is the
  // input delayed by STAGES edges, and the level flips when the last
  // FILTER_CYC samples all disagree with it.
  logic [3:0] hist [0:4095];
  int         n;
  logic [3:0] m_lvl_a, m_rise_a, m_fall_a, m_busy_a;
  logic [3:0] m_lvl_b, m_rise_b, m_fall_b, m_busy_b;

  function automatic logic smp_at(input int e, input int stages,
                                  input logic [3:0] rv, input int ch);
    int idx;
    idx = e - stages;
    if (idx < 0) return rv[ch];
    return hist[idx][ch];
  endfunction

  task automatic model_step(input int e, input int stages, input int fc,
                            input logic [3:0] rv, inout logic [3:0] lvl,
                            output logic [3:0] r, output logic [3:0] f,
                            output logic [3:0] b);
    r = '0; f = '0; b = '0;
    for (int ch = 0; ch < 4; ch++) begin
      logic old_l, new_l, acc;
      old_l = lvl[ch];
      acc   = 1'b1;
      for (int k = 0; k < fc; k++)
        if (smp_at(e - k, stages, rv, ch) == old_l) acc = 1'b0;
      new_l   = acc ? ~old_l : old_l;
      r[ch]   = ~old_l & new_l;
      f[ch]   = old_l & ~new_l;
      b[ch]   = smp_at(e, stages, rv, ch) != new_l;
      lvl[ch] = new_l;
    end
  endtask

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      m_lvl_a = A_RV; m_rise_a = '0; m_fall_a = '0; m_busy_a = '0;
      m_lvl_b = B_RV; m_rise_b = '0; m_fall_b = '0; m_busy_b = '0;
    end else if (n < 4096) begin
      hist[n] = async_in;
      model_step(n, A_ST, A_FC, A_RV, m_lvl_a, m_rise_a, m_fall_a, m_busy_a);
      model_step(n, B_ST, B_FC, B_RV, m_lvl_b, m_rise_b, m_fall_b, m_busy_b);
      n = n + 1;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("a_sync", so_a, m_lvl_a);
      chk("a_rise", rp_a, m_rise_a);
      chk("a_fall", fp_a, m_fall_a);
      chk("a_busy", bz_a, m_busy_a);
      chk("b_sync", so_b, m_lvl_b);
      chk("b_rise", rp_b, m_rise_b);
      chk("b_fall", fp_b, m_fall_b);
      chk("b_busy", bz_b, m_busy_b);
      if (bz_b != 4'h0) busy_b_seen = 1'b1;
    end
  end

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] pat  [8];
  int         hold [8];

  initial begin
    pat  = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h6, 4'h9, 4'hF, 4'h0};
    hold = '{1, 2, 3, 4, 2, 5, 1, 6};
    rst_n    = 1'b1;
    async_in = 4'hF;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset held with inputs high
    repeat (5) @(negedge clock);
    chk("rst_sync_a", so_a, 4'b0000);
    chk("rst_sync_b", so_b, 4'b1000);
    chk("rst_busy_a", bz_a, 4'b0000);
    chk("rst_rise_a", rp_a, 4'b0000);
    async_in = 4'h0;
    rst_n    = 1'b1;
    repeat (6) @(negedge clock);
    chk("rel_sync_a", so_a, 4'b0000);
    chk("rel_sync_b", so_b, 4'b0000);

    // Rise latency on channel 0
    async_in = 4'h1;
    @(posedge clock);                       // E0
    after_edge();                           // E0+1
    chk("rise_busy_e1", 4'(bz_a[0]), 4'd0);
    after_edge();                           // E0+2
    chk("rise_busy_e2", 4'(bz_a[0]), 4'd1);
    chk("b_sync_e2", 4'(so_b[0]), 4'd0);
    after_edge();                           // E0+3
    chk("rise_sync_e3", 4'(so_a[0]), 4'd0);
    chk("rise_busy_e3", 4'(bz_a[0]), 4'd1);
    chk("b_rise_e3", 4'(rp_b[0]), 4'd1);
    after_edge();                           // E0+4
    chk("rise_sync_e4", 4'(so_a[0]), 4'd1);
    chk("rise_pulse_e4", 4'(rp_a[0]), 4'd1);
    chk("rise_busy_e4", 4'(bz_a[0]), 4'd0);
    after_edge();                           // E0+5
    chk("rise_pulse_e5", 4'(rp_a[0]), 4'd0);
    chk("rise_busy_e5", 4'(bz_a[0]), 4'd0);

    // Two-cycle glitch on channel 1
    @(negedge clock);
    async_in = 4'h3;
    @(posedge clock);                       // E0
    @(posedge clock);                       // E0+1
    @(negedge clock);
    async_in = 4'h1;
    after_edge();                           // E0+2
    chk("glitch_busy_e2", 4'(bz_a[1]), 4'd1);
    after_edge();                           // E0+3
    chk("glitch_busy_e3", 4'(bz_a[1]), 4'd1);
    after_edge();                           // E0+4
    chk("glitch_busy_e4", 4'(bz_a[1]), 4'd0);
    chk("glitch_sync_e4", 4'(so_a[1]), 4'd0);
    after_edge();
    chk("glitch_rise_e5", 4'(rp_a[1]), 4'd0);

    // Simultaneous fall on channels 0 and 2
    @(negedge clock);
    async_in = 4'h5;
    repeat (6) @(negedge clock);
    chk("fall_pre_sync", so_a, 4'h5);
    async_in = 4'h0;
    @(posedge clock);                       // E0
    @(posedge clock);
    @(posedge clock);
    after_edge();                           // E0+3
    chk("fall_e3", fp_a, 4'b0000);
    after_edge();                           // E0+4
    chk("fall_e4", fp_a, 4'b0101);
    chk("fall_sync_e4", so_a, 4'b0000);
    after_edge();                           // E0+5
    chk("fall_e5", fp_a, 4'b0000);

    // Reset while channel 3 has a pending count of 2
    @(negedge clock);
    async_in = 4'h8;
    @(posedge clock);                       // E0
    @(posedge clock);
    @(posedge clock);
    after_edge();                           // E0+3
    chk("mid_busy_pre", 4'(bz_a[3]), 4'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_busy_rst", bz_a, 4'b0000);
    chk("mid_sync_rst", 4'(so_a[3]), 4'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);                       // E'0
    @(posedge clock);
    @(posedge clock);
    after_edge();                           // E'0+3
    chk("mid_sync_e3", 4'(so_a[3]), 4'd0);
    after_edge();                           // E'0+4
    chk("mid_sync_e4", 4'(so_a[3]), 4'd1);
    chk("mid_rise_e4", 4'(rp_a[3]), 4'd1);
    chk("mid_b_sync", so_b, 4'b1000);
    chk("mid_b_rise", rp_b, 4'b0000);

    // Table of patterns with assorted hold times
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      async_in = pat[i];
      repeat (hold[i] - 1) @(negedge clock);
    end
    repeat (8) @(negedge clock);
    chk("b_busy_never", 4'(busy_b_seen), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
